// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_unit
// Brief    : Iterative radix-2 shift-add RV32M multiplier (MUL/MULH/MULHSU/
//            MULHU). Operates on operand magnitudes and applies the sign at
//            the end, so one unsigned datapath serves all four operations.
// Revision : 1.0 - initial release
// ============================================================================
module mul_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      mulctl,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            exdone,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0]   ONE_X    = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE_2X   = (2*XLEN)'(1);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic              neg_q, neg_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              rs1_signed, rs2_signed;
    logic              rs1_neg, rs2_neg;
    logic [XLEN-1:0]   rs1_mag, rs2_mag;
    logic [XLEN:0]     step_sum;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_final;

    // Operand magnitudes and one shift-add step; the most-negative value maps
    // onto itself, which is its correct unsigned magnitude.
    always_comb begin
        rs1_signed = (mulctl == OP_MULH) || (mulctl == OP_MULHSU);
        rs2_signed = (mulctl == OP_MULH);
        rs1_neg    = rs1_signed & rs1[XLEN-1];
        rs2_neg    = rs2_signed & rs2[XLEN-1];
        rs1_mag    = rs1_neg ? (~rs1 + ONE_X) : rs1;
        rs2_mag    = rs2_neg ? (~rs2 + ONE_X) : rs2;
        step_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                   + (mplier_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        acc_step   = {step_sum, acc_q[XLEN-1:1]};
        prod_final = neg_q ? (~acc_step + ONE_2X) : acc_step;
    end

    // State register (asynchronous reset abandons any operation in flight).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is honoured only in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (count_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy   = (state_q != S_IDLE);
        exdone = (state_q == S_DONE);
    end

    // Datapath next values: capture in IDLE, iterate in RUN, and write the
    // result on the final RUN edge so it is valid as exdone rises.
    always_comb begin
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = rs1_mag;
                    mplier_d = rs2_mag;
                    neg_d    = rs1_neg ^ rs2_neg;
                    op_d     = mulctl;
                    count_d  = CNT_LAST;
                    acc_d    = '0;
                end
            end
            S_RUN: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                if (count_q == '0) begin
                    result_d = (op_q == OP_MUL) ? prod_final[XLEN-1:0]
                                                : prod_final[2*XLEN-1:XLEN];
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_unit
// Brief    : Scoreboard bench for mul_unit: directed RV32M corner cases,
//            ignored-start and mid-run reset scenarios, then random operations
//            checked against a 64-bit arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_unit;

    localparam int XLEN    = 32;
    localparam int LATENCY = 33;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      mulctl = 2'b00;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            busy;
    logic            exdone;
    logic [XLEN-1:0] result;

    typedef struct {
        logic [XLEN-1:0] res;
        int              cyc;
    } exp_t;

    exp_t            sb[$];
    int              cyc = 0;
    int              errors = 0;
    int              checks = 0;
    logic [XLEN-1:0] last_res = '0;

    mul_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mulctl (mulctl),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .exdone (exdone),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full product of the sign/zero-extended operands, modulo 2^64.
    function automatic logic [XLEN-1:0] model(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] ea, eb, p;
        ea = (op == 2'b01 || op == 2'b10) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        eb = (op == 2'b01) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every exdone must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && exdone) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_exdone: got exdone=1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("latency", XLEN'(cyc), XLEN'(e.cyc));
                last_res = e.res;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
        @(negedge clk);
        mulctl = op;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        sb.push_back('{exp, cyc + LATENCY});
        @(negedge clk);
        start  = 1'b0;
        rs1    = $urandom;
        rs2    = $urandom;
        mulctl = 2'($urandom);
        check("busy_after_start", XLEN'(busy), XLEN'(1));
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        check("busy_after_done", XLEN'(busy), XLEN'(0));
        check("exdone_one_cycle", XLEN'(exdone), XLEN'(0));
    endtask

    logic [XLEN-1:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        // Reset state
        #12;
        check("reset_busy", XLEN'(busy), XLEN'(0));
        check("reset_exdone", XLEN'(exdone), XLEN'(0));
        check("reset_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        issue(2'b00, 32'd7, 32'd6, 32'h0000_002A);
        wait_done();
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_done();
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        wait_done();
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_done();
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        wait_done();
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        wait_done();
        issue(2'b01, 32'h0, 32'hFFFF_FFFF, 32'h0000_0000);
        wait_done();

        // Result holds across idle
        repeat (5) @(negedge clk);
        check("result_hold", result, last_res);

        // Start re-pulsed mid-run with different operands is ignored
        issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, model(2'b11, 32'h1234_5678, 32'h9ABC_DEF0));
        repeat (8) @(negedge clk);
        start = 1'b1; mulctl = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
        @(negedge clk);
        start = 1'b0; rs1 = 32'hDEAD_BEEF;
        wait_done();

        // Start during the DONE cycle is ignored
        issue(2'b01, 32'hFFFF_FFF9, 32'd100, model(2'b01, 32'hFFFF_FFF9, 32'd100));
        begin
            int n = 0;
            while (exdone !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        start = 1'b1; mulctl = 2'b00; rs1 = 32'd9; rs2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", XLEN'(busy), XLEN'(0));
        wait_done();
        repeat (40) @(negedge clk);
        check("still_idle", XLEN'(busy), XLEN'(0));

        // Asynchronous reset mid-run abandons the operation
        issue(2'b00, 32'd11, 32'd13, 32'd143);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", XLEN'(busy), XLEN'(0));
        check("async_rst_exdone", XLEN'(exdone), XLEN'(0));
        check("async_rst_result", result, '0);
        sb.delete();
        last_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("no_done_after_rst", XLEN'(busy), XLEN'(0));
        issue(2'b00, 32'd11, 32'd13, 32'd143);
        wait_done();

        // Random operations with a bias toward corner operands
        for (int i = 0; i < 40; i++) begin
            logic [1:0]      op;
            logic [XLEN-1:0] a, b;
            op = 2'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : XLEN'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : XLEN'($urandom);
            issue(op, a, b, model(op, a, b));
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
